waveform_capture_checker: RTL

Receive-side checker for the AWG pulse stream: it takes the 192-bit, 12-lane sample words that the waveform generator produces on sys_clk and decodes them back into pulse parameters. It measures valid-run and zero-run lengths, compares them with the programmed durations and amplitudes, and counts periods and errors. It sits on sys_clk beside the generator, either tapping its output bus or fed by a loopback capture path. Its results go to VIO/ILA for closed-loop self-test.

---
 rtl/waveform_capture_checker.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/waveform_capture_checker.sv
// Receive-side pulse checker: decodes AWG sample words into valid/zero runs and checks lengths and amplitudes.
// Optional macro WAVE_CHK_ALL_LANES_EN compares all lanes; by default only lane 0 is compared.
module waveform_capture_checker #(
    parameter int LANES = 12,
    parameter int CNT_W = 16
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  i_arm,
    input  logic                  i_stop,
    input  logic [15:0]           i_valid_amp,
    input  logic [15:0]           i_zero_amp,
    input  logic [31:0]           i_data_duration,
    input  logic [31:0]           i_zero_duration,
    input  logic                  i_data_vld,
    input  logic [LANES*16-1:0]   i_data,
    output logic                  o_busy,
    output logic                  o_period_done,
    output logic [CNT_W-1:0]      o_period_cnt,
    output logic [CNT_W-1:0]      o_len_err_cnt,
    output logic [CNT_W-1:0]      o_amp_err_cnt,
    output logic                  o_err,
    output logic [31:0]           o_last_valid_len,
    output logic [31:0]           o_last_zero_len
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_IN_VALID,
        ST_IN_ZERO
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_periodDone;
    logic [CNT_W-1:0]   r_periodCnt;
    logic [CNT_W-1:0]   r_lenErrCnt;
    logic [CNT_W-1:0]   r_ampErrCnt;
    logic               r_err;
    logic [31:0]        r_lastValidLen;
    logic [31:0]        r_lastZeroLen;
    logic [31:0]        r_run;

    logic               w_allValid;
    logic               w_allZero;
    logic               w_isValid;
    logic               w_isZero;

`ifdef WAVE_CHK_ALL_LANES_EN
    always_comb begin
        w_allValid = 1'b1;
        w_allZero  = 1'b1;
        for (int k = 0; k < LANES; k++) begin
            if (i_data[16*k +: 16] != i_valid_amp) w_allValid = 1'b0;
            if (i_data[16*k +: 16] != i_zero_amp)  w_allZero  = 1'b0;
        end
    end
`else
    logic w_unusedLanes;
    assign w_unusedLanes = ^i_data[LANES*16-1:16];
    assign w_allValid    = (i_data[15:0] == i_valid_amp);
    assign w_allZero     = (i_data[15:0] == i_zero_amp);
`endif

    // VALID has priority when both amplitudes are programmed equal
    assign w_isValid = w_allValid;
    assign w_isZero  = w_allZero && !w_allValid;

    function automatic logic [CNT_W-1:0] satIncCnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [31:0] satIncRun(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_busy         <= 1'b0;
            r_periodDone   <= 1'b0;
            r_periodCnt    <= '0;
            r_lenErrCnt    <= '0;
            r_ampErrCnt    <= '0;
            r_err          <= 1'b0;
            r_lastValidLen <= '0;
            r_lastZeroLen  <= '0;
            r_run          <= '0;
        end else begin
            r_periodDone <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (i_arm && !i_stop) begin
                    r_state        <= ST_WAIT_START;
                    r_busy         <= 1'b1;
                    r_periodCnt    <= '0;
                    r_lenErrCnt    <= '0;
                    r_ampErrCnt    <= '0;
                    r_err          <= 1'b0;
                    r_lastValidLen <= '0;
                    r_lastZeroLen  <= '0;
                    r_run          <= '0;
                end
            end else if (i_stop) begin
                // abort drops the partial run without comparing it
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
            end else if (i_data_vld) begin
                case (r_state)
                    ST_WAIT_START: begin
                        if (w_isValid) begin
                            r_run   <= 32'd1;
                            r_state <= ST_IN_VALID;
                        end
                    end
                    ST_IN_VALID: begin
                        if (w_isZero) begin
                            r_lastValidLen <= r_run;
                            if (r_run != i_data_duration) begin
                                r_lenErrCnt <= satIncCnt(r_lenErrCnt);
                                r_err       <= 1'b1;
                            end
                            r_run   <= 32'd1;
                            r_state <= ST_IN_ZERO;
                        end else begin
                            r_run <= satIncRun(r_run);
                            if (!w_isValid) begin
                                r_ampErrCnt <= satIncCnt(r_ampErrCnt);
                                r_err       <= 1'b1;
                            end
                        end
                    end
                    ST_IN_ZERO: begin
                        if (w_isValid) begin
                            r_lastZeroLen <= r_run;
                            if (r_run != i_zero_duration) begin
                                r_lenErrCnt <= satIncCnt(r_lenErrCnt);
                                r_err       <= 1'b1;
                            end
                            r_periodCnt  <= satIncCnt(r_periodCnt);
                            r_periodDone <= 1'b1;
                            r_run        <= 32'd1;
                            r_state      <= ST_IN_VALID;
                        end else begin
                            r_run <= satIncRun(r_run);
                            if (!w_isZero) begin
                                r_ampErrCnt <= satIncCnt(r_ampErrCnt);
                                r_err       <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_busy           = r_busy;
    assign o_period_done    = r_periodDone;
    assign o_period_cnt     = r_periodCnt;
    assign o_len_err_cnt    = r_lenErrCnt;
    assign o_amp_err_cnt    = r_ampErrCnt;
    assign o_err            = r_err;
    assign o_last_valid_len = r_lastValidLen;
    assign o_last_zero_len  = r_lastZeroLen;

endmodule
